// File: rtl/alu_pkg.sv
// Shared ALU operation codes and scheduler FSM encoding.
// Pure declarations, no latency and no handshake of its own.
// Imported by the ALU, the arbiter and the scheduler top.
package alu_pkg;

    localparam int OPW = 3;

    localparam logic [OPW-1:0] OP_ADD  = 3'b000;
    localparam logic [OPW-1:0] OP_SUB  = 3'b001;
    localparam logic [OPW-1:0] OP_MAX  = 3'b010;
    localparam logic [OPW-1:0] OP_MIN  = 3'b011;
    localparam logic [OPW-1:0] OP_AND  = 3'b100;
    localparam logic [OPW-1:0] OP_OR   = 3'b101;
    localparam logic [OPW-1:0] OP_XOR  = 3'b110;
    localparam logic [OPW-1:0] OP_PASS = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu.sv
// Shared signed ALU, nIO-bit two's complement operands and result.
// Purely combinational, zero cycles of latency.
// No handshake; the caller holds the operands stable while it samples Z/OV.
module alu
    import alu_pkg::*;
#(
    parameter int nIO = 8
) (
    input  logic [nIO-1:0] a,
    input  logic [nIO-1:0] b,
    input  logic [OPW-1:0] op,
    output logic [nIO-1:0] z,
    output logic           ov
);

    logic [nIO-1:0] sum;
    logic [nIO-1:0] dif;
    logic           a_lt_b;

    assign sum    = a + b;
    assign dif    = a - b;
    assign a_lt_b = $signed(a) < $signed(b);

    // OV is only meaningful for ADD/SUB; all other ops report no overflow.
    always_comb begin
        z  = '0;
        ov = 1'b0;
        case (op)
            OP_ADD: begin
                z  = sum;
                ov = (a[nIO-1] == b[nIO-1]) && (sum[nIO-1] != a[nIO-1]);
            end
            OP_SUB: begin
                z  = dif;
                ov = (a[nIO-1] != b[nIO-1]) && (dif[nIO-1] != a[nIO-1]);
            end
            OP_MAX:  z = a_lt_b ? b : a;
            OP_MIN:  z = a_lt_b ? a : b;
            OP_AND:  z = a & b;
            OP_OR:   z = a | b;
            OP_XOR:  z = a ^ b;
            OP_PASS: z = a;
            default: z = '0;
        endcase
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin priority search over req starting at ptr, wrapping modulo NREQ.
// Combinational, zero cycles of latency.
// gnt is one-hot or zero; the caller decides whether a grant is taken.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx
);

    logic found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[(int'(ptr) + i) % NREQ]) begin
                found = 1'b1;
                gnt[(int'(ptr) + i) % NREQ] = 1'b1;
                idx = IDW'((int'(ptr) + i) % NREQ);
            end
        end
    end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Round-robin sharing of one ALU between NREQ requesters, one op in flight.
// Accept at edge N, registered result with rsp_valid after edge N+1.
// req_ready only in IDLE; the response holds until rsp_ready, stalling all requesters.
module alu_rr_scheduler
    import alu_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int nIO  = 8,
    parameter int IDW  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*nIO-1:0] req_a,
    input  logic [NREQ*nIO-1:0] req_b,
    input  logic [NREQ*OPW-1:0] req_op,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [nIO-1:0]      rsp_z,
    output logic                rsp_ov
);

    typedef struct packed {
        logic [nIO-1:0] a;
        logic [nIO-1:0] b;
        logic [OPW-1:0] op;
        logic [IDW-1:0] id;
    } job_t;

    state_t          state;
    state_t          state_nxt;
    logic [IDW-1:0]  rr_ptr;
    job_t            job;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gidx;
    logic            accept;
    logic [nIO-1:0]  alu_z;
    logic            alu_ov;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req (req_valid),
        .ptr (rr_ptr),
        .gnt (gnt),
        .idx (gidx)
    );

    alu #(
        .nIO (nIO)
    ) u_alu (
        .a  (job.a),
        .b  (job.b),
        .op (job.op),
        .z  (alu_z),
        .ov (alu_ov)
    );

    // Gated by rst_n so nothing is accepted while reset is held.
    assign req_ready = (rst_n && state == IDLE) ? gnt : '0;
    assign accept    = |req_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = EXEC;
            EXEC:                   state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            job       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_z     <= '0;
            rsp_ov    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                job.a  <= req_a[int'(gidx) * nIO +: nIO];
                job.b  <= req_b[int'(gidx) * nIO +: nIO];
                job.op <= req_op[int'(gidx) * OPW +: OPW];
                job.id <= gidx;
                rr_ptr <= (int'(gidx) == NREQ - 1) ? '0 : gidx + IDW'(1);
            end
            if (state == EXEC) begin
                rsp_z     <= alu_z;
                rsp_ov    <= alu_ov;
                rsp_id    <= job.id;
                rsp_valid <= 1'b1;
            end
            if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Bench for alu_rr_scheduler: vector table, directed multi-cycle sequences,
// and a randomized run scored against a queue-based reference model.
module tb_alu_rr_scheduler;

    localparam int NREQ = 4;
    localparam int NIO  = 8;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*NIO-1:0] req_a = '0;
    logic [NREQ*NIO-1:0] req_b = '0;
    logic [NREQ*3-1:0]   req_op = '0;
    logic                rsp_valid;
    logic                rsp_ready = 1'b0;
    logic [IDW-1:0]      rsp_id;
    logic [NIO-1:0]      rsp_z;
    logic                rsp_ov;

    always #5 clk = ~clk;

    alu_rr_scheduler #(
        .NREQ (NREQ),
        .nIO  (NIO),
        .IDW  (IDW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_z     (rsp_z),
        .rsp_ov    (rsp_ov)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         id;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic [7:0] z;
        logic       ov;
    } vec_t;

    typedef struct {
        int         k;
        logic [7:0] a;
        logic [7:0] b;
    } rop_t;

    typedef struct {
        int         id;
        logic [7:0] z;
    } exp_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] smin(input logic [7:0] a, input logic [7:0] b);
        return ($signed(a) < $signed(b)) ? a : b;
    endfunction

    task automatic set_req(input int k, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        req_a[k*NIO +: NIO] = a;
        req_b[k*NIO +: NIO] = b;
        req_op[k*3 +: 3]    = op;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Runs from posedge+1 until a grant is seen; returns at posedge+1 after the accept edge.
    task automatic wait_grant(output logic [NREQ-1:0] g, input int budget);
        g = '0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (req_ready != '0) g = req_ready;
            @(posedge clk);
            #1;
            if (g != '0) break;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    vec_t            vt[7];
    rop_t            ops[20];
    exp_t            expq[$];
    exp_t            e;
    int              head[NREQ];
    int              order[5];
    logic [7:0]      a2[NREQ];
    logic [7:0]      b2[NREQ];
    logic [NREQ-1:0] g;
    int              ng, nr, nrsp, mptr, ek, ak, kk;

    function automatic int next_op(input int k, input int from);
        for (int i = from; i < 20; i++) if (ops[i].k == k) return i;
        return 20;
    endfunction

    initial begin
        vt[0] = '{2, 8'd5,   8'hFD, 3'b011, 8'hFD, 1'b0};
        vt[1] = '{0, 8'h80,  8'h7F, 3'b011, 8'h80, 1'b0};
        vt[2] = '{1, 8'h7F,  8'h7F, 3'b011, 8'h7F, 1'b0};
        vt[3] = '{3, 8'hFF,  8'h00, 3'b011, 8'hFF, 1'b0};
        vt[4] = '{1, 8'd100, 8'h9C, 3'b011, 8'h9C, 1'b0};
        vt[5] = '{3, 8'd100, 8'd100, 3'b000, 8'hC8, 1'b1};
        vt[6] = '{0, 8'h80,  8'h01, 3'b001, 8'h7F, 1'b1};

        // Reset state
        do_reset();
        @(negedge clk);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_id", rsp_id, 0);
        chk("reset_rsp_z", rsp_z, 0);
        chk("reset_rsp_ov", rsp_ov, 0);
        chk("reset_req_ready", req_ready, 0);
        @(posedge clk);
        #1;

        // Single-requester vectors: grant same cycle, response two edges later
        for (int i = 0; i < 7; i++) begin
            set_req(vt[i].id, vt[i].a, vt[i].b, vt[i].op);
            req_valid = 4'(1 << vt[i].id);
            rsp_ready = 1'b0;
            @(negedge clk);
            chk("vec_ready", req_ready, 1 << vt[i].id);
            @(posedge clk);
            #1 req_valid = '0;
            @(negedge clk);
            chk("vec_exec_quiet", {rsp_valid, req_ready}, 0);
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("vec_rsp_valid", rsp_valid, 1);
            chk("vec_rsp_id", rsp_id, vt[i].id);
            chk("vec_rsp_z", rsp_z, vt[i].z);
            chk("vec_rsp_ov", rsp_ov, vt[i].ov);
            rsp_ready = 1'b1;
            @(posedge clk);
            #1 rsp_ready = 1'b0;
            @(negedge clk);
            chk("vec_rsp_drop", rsp_valid, 0);
            @(posedge clk);
            #1;
        end

        // All requesters valid continuously from reset
        do_reset();
        a2 = '{8'd10, 8'hF0, 8'd3, 8'h80};
        b2 = '{8'hFB, 8'd20, 8'd3, 8'd1};
        order = '{0, 1, 2, 3, 0};
        for (int k = 0; k < NREQ; k++) set_req(k, a2[k], b2[k], 3'b011);
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        ng = 0;
        nr = 0;
        for (int c = 0; c < 40 && nr < 5; c++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                if (ng < 5) chk("rr_order", req_ready, 1 << order[ng]);
                ng++;
            end
            if (rsp_valid) begin
                chk("rr_rsp_id", rsp_id, order[nr]);
                chk("rr_rsp_z", rsp_z, smin(a2[order[nr]], b2[order[nr]]));
                nr++;
            end
            @(posedge clk);
            #1;
        end
        chk("rr_rsp_count", nr, 5);

        // Response backpressure with requester 1 pending
        do_reset();
        set_req(0, 8'd7, 8'd9, 3'b011);
        set_req(1, 8'hFE, 8'd4, 3'b011);
        req_valid = 4'b0011;
        wait_grant(g, 5);
        chk("bp_first_grant", g, 4'b0001);
        req_valid = 4'b0010;
        @(posedge clk);
        #1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_hold", {rsp_valid, rsp_id, rsp_z, req_ready}, {1'b1, 2'd0, 8'd7, 4'b0000});
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        chk("bp_next_grant", req_ready, 4'b0010);
        @(posedge clk);
        #1 req_valid = '0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_second_rsp", {rsp_valid, rsp_id, rsp_z}, {1'b1, 2'd1, 8'hFE});
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;

        // Fairness: requester 0 continuous, requester 3 joins
        do_reset();
        set_req(0, 8'd1, 8'd2, 3'b011);
        set_req(3, 8'd5, 8'h85, 3'b011);
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        wait_grant(g, 5);
        chk("fair_first", g, 4'b0001);
        req_valid = 4'b1001;
        wait_grant(g, 10);
        chk("fair_req3_next", g, 4'b1000);
        req_valid = 4'b0001;
        wait_grant(g, 10);
        chk("fair_req0_again", g, 4'b0001);
        req_valid = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            wait_grant(g, 10);
            chk("fair_alternate", g, (i % 2 == 0) ? 4'b1000 : 4'b0001);
        end
        req_valid = '0;

        // Reset while in EXEC drops the operation and rewinds the pointer
        do_reset();
        set_req(2, 8'd9, 8'd4, 3'b011);
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        wait_grant(g, 5);
        chk("rst_pre_grant", g, 4'b0100);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_ready_low", req_ready, 0);
        @(posedge clk);
        #1;
        set_req(1, 8'h90, 8'd2, 3'b011);
        set_req(3, 8'd6, 8'd8, 3'b011);
        req_valid = 4'b1010;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_no_rsp", rsp_valid, 0);
        chk("rst_ptr_grant", req_ready, 4'b0010);
        @(posedge clk);
        #1 req_valid = '0;
        @(negedge clk);
        chk("rst_exec_no_rsp", rsp_valid, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_next_rsp", {rsp_valid, rsp_id, rsp_z}, {1'b1, 2'd1, 8'h90});
        @(posedge clk);
        #1;

        // Randomized run against a reference scoreboard
        do_reset();
        for (int i = 0; i < 20; i++) begin
            ops[i].k = int'($urandom_range(0, NREQ - 1));
            ops[i].a = 8'($urandom);
            ops[i].b = 8'($urandom);
        end
        for (int k = 0; k < NREQ; k++) head[k] = next_op(k, 0);
        mptr = 0;
        nrsp = 0;
        for (int c = 0; c < 2000 && nrsp < 20; c++) begin
            for (int k = 0; k < NREQ; k++) begin
                if (head[k] < 20) begin
                    req_valid[k] = 1'b1;
                    set_req(k, ops[head[k]].a, ops[head[k]].b, 3'b011);
                end else begin
                    req_valid[k] = 1'b0;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (req_ready != '0) begin
                ek = -1;
                for (int j = 0; j < NREQ; j++) begin
                    kk = (mptr + j) % NREQ;
                    if (ek < 0 && req_valid[kk]) ek = kk;
                end
                chk("rand_grant", req_ready, (ek < 0) ? 0 : (1 << ek));
                ak = -1;
                for (int j = NREQ - 1; j >= 0; j--) if (req_ready[j]) ak = j;
                if (head[ak] < 20) begin
                    e.id = ak;
                    e.z  = smin(ops[head[ak]].a, ops[head[ak]].b);
                    expq.push_back(e);
                    head[ak] = next_op(ak, head[ak] + 1);
                end
                mptr = (ak + 1) % NREQ;
            end
            if (rsp_valid && rsp_ready) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rand_extra_rsp: got id %0d z %0h with nothing outstanding", rsp_id, rsp_z);
                end else begin
                    e = expq.pop_front();
                    chk("rand_rsp_id", rsp_id, e.id);
                    chk("rand_rsp_z", rsp_z, e.z);
                    chk("rand_rsp_ov", rsp_ov, 0);
                end
                nrsp++;
            end
            @(posedge clk);
            #1;
        end
        chk("rand_rsp_count", nrsp, 20);
        chk("rand_outstanding", expq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
